// File: rtl/shift_tx_pkg.sv
// Shared types and sizing helpers for the two-source serial transmit scheduler.
package shift_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam int GAP_W = 4;

  // Bit counter width for a given word width; never narrower than one bit.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Parallel-load, shift-left register with zero fill; load wins over shift.
module shift_reg_core
  import shift_tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = data_in;
    end else if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign data_out = sr_q;

endmodule

// File: rtl/shift_tx_scheduler.sv
// Round-robin scheduler for two word sources feeding an MSB-first serial line
// with frame start/end strobes and an optional idle gap after each frame.
module shift_tx_scheduler
  import shift_tx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             grant_id,
  output logic             busy
);

  localparam int                 COUNT_W  = count_width(WIDTH);
  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0]   LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ptr_q, ptr_d;
  logic               gid_q, gid_d;

  logic             win1;
  logic             in_idle;
  logic             xfer;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] sr_out;

  // A lone requester wins outright; on a tie the pointer decides.
  always_comb begin
    win1 = 1'b0;
    if (req0_valid && req1_valid) begin
      win1 = ptr_q;
    end else if (req1_valid) begin
      win1 = 1'b1;
    end
  end

  // Readies are gated by rst so every output is low while reset is held.
  assign in_idle    = rst && (state_q == S_IDLE);
  assign req0_ready = in_idle && req0_valid && !win1;
  assign req1_ready = in_idle && req1_valid && win1;
  assign xfer       = req0_ready || req1_ready;
  assign win_data   = win1 ? req1_data : req0_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          load    = 1'b1;
          gid_d   = win1;
          ptr_d   = ~win1;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          gap_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + COUNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == LAST_GAP) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= 1'b0;
      gid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
    end
  end

  shift_reg_core #(
    .WIDTH(WIDTH)
  ) u_sr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .data_in (win_data),
    .data_out(sr_out)
  );

  // Serial outputs decode straight from state so reset silences them at once.
  assign sdo_valid   = (state_q == S_SHIFT);
  assign sdo         = sdo_valid && sr_out[WIDTH-1];
  assign frame_start = sdo_valid && (cnt_q == '0);
  assign frame_end   = sdo_valid && (cnt_q == LAST_CNT);
  assign grant_id    = gid_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/shift_tx_scheduler.md
Name: shift_tx_scheduler

Overview:
- Two-requester parallel-to-serial transmit scheduler.
- Arbitrates round-robin between two valid/ready word sources and sequences load/shift-left on an internal WIDTH-bit shift register.
- Streams each accepted word MSB-first on a single serial line, with frame strobes.
- Sits between producer logic and a serial link or pin driver.

Parameters:
- WIDTH, 4: word width in bits; legal range 2 or greater.
- GAP, 1: idle cycles inserted after each frame; legal range 0 to 15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- sdo  output  1  serial data, MSB first.
- sdo_valid  output  1  sdo carries a frame bit.
- frame_start  output  1  high on the first bit of a frame.
- frame_end  output  1  high on the last bit of a frame.
- grant_id  output  1  source of the frame in flight (0 or 1).
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset (rst low, asynchronous; release synchronous to clk):
  - State goes to IDLE; shift register, bit counter and gap counter clear to 0.
  - Priority pointer set so req0 wins the first tie.
  - All outputs 0.
- FSM states:
  - IDLE: ready is combinational, asserted only to the arbitration winner, and only when that requester's valid is high.
    - Exactly one ready is high per cycle, at most.
    - Transfer occurs on the edge where valid && ready.
    - On that edge: shift register loads the winner's data, grant_id registers the winner, pointer flips to the other requester, counter goes to 0, state goes to SHIFT.
    - With no valid, stay in IDLE.
  - SHIFT: sdo = shift register MSB; sdo_valid = 1; both readys = 0.
    - Every cycle, shift left with zero fill and increment the counter.
    - frame_start = 1 when count == 0; frame_end = 1 when count == WIDTH-1.
    - At count == WIDTH-1, go to GAP if GAP > 0, otherwise to IDLE.
  - GAP: sdo = 0, sdo_valid = 0, readys = 0; hold for GAP cycles, then go to IDLE.
- Arbitration:
  - Only one valid: that requester wins, regardless of the pointer.
  - Both valid: the pointer's requester wins.
  - The pointer updates only on an accepted transfer.
- Latency and throughput:
  - Word accepted at edge N; first bit visible in the cycle after edge N; last bit at N+WIDTH.
  - Minimum frame period is WIDTH+GAP+1 cycles, because one IDLE cycle always sits between frames.
- Output rules:
  - sdo is forced to 0 whenever sdo_valid = 0.
  - frame_start and frame_end are both high in the same cycle only if WIDTH = 1, which is illegal.
  - grant_id holds its last value in GAP and IDLE.
- Protocol:
  - A requester keeps valid and data stable until ready.
  - The block tolerates valid dropping without ready: no transfer occurs and no pointer change.
- Reset mid-frame:
  - The frame aborts; sdo_valid drops immediately, asynchronously.
  - No partial frame resumes after release.
- The counter is sized to COUNT_W bits; it never wraps past WIDTH-1.

Decomposition:
- Shared package shift_tx_pkg:
  - state enum: IDLE, SHIFT, GAP.
  - localparam COUNT_W = $clog2(WIDTH).
  - localparam GAP_W = 4.
- One sub-module, shift_reg_core:
  - Parameterised WIDTH register with clk, rst (async active-low), load, shift, data_in, data_out.
  - load has priority over shift; shift is left with zero fill.
- The top holds the FSM, arbiter, counters and strobes.

Test Plan:
1. Reset then single word: rst low 3 cycles then high; req0_valid with data 4'b1011.
   - Response: req0_ready for 1 cycle; next 4 cycles sdo = 1,0,1,1 with sdo_valid = 1; frame_start on bit 1, frame_end on bit 4; grant_id = 0.
   - Then 1 GAP cycle and 1 IDLE cycle before the next accept.
2. Contention: req0 (4'b1100) and req1 (4'b0011) valid together and held.
   - Response: frames alternate req0, req1, req0, req1; grant_id = 0,1,0,1; accepts 6 cycles apart.
3. GAP = 0 back-to-back: req1 streams 4'b1111 then 4'b0001.
   - Response: accepts 5 cycles apart; sdo = 1111, one invalid cycle, then 0001.
4. Reset mid-frame: assert rst after bit 2 of 4'b1010.
   - Response: sdo_valid, sdo and busy are 0 immediately.
   - After release, no remaining bits appear; req0 wins the next tie.
5. Valid withdrawn: req1_valid pulses high for one cycle while in SHIFT, then drops.
   - Response: no req1_ready and no extra frame; the pointer is unchanged.
6. Idle hold: no valid for 20 cycles.
   - Response: state stays IDLE; sdo, sdo_valid and busy stay 0; readys stay 0.
